// File: rtl/jtag_tap_pkg.sv
// Shared types for the JTAG TAP / RISC-V DTM: TAP states, IR codes, DTM op codes.
package jtag_tap_pkg;

    localparam int unsigned IrWidth      = 5;
    localparam logic [3:0]  DtmcsVersion = 4'd1;

    typedef enum logic [3:0] {
        TestLogicReset,
        RunTestIdle,
        SelectDrScan,
        CaptureDr,
        ShiftDr,
        Exit1Dr,
        PauseDr,
        Exit2Dr,
        UpdateDr,
        SelectIrScan,
        CaptureIr,
        ShiftIr,
        Exit1Ir,
        PauseIr,
        Exit2Ir,
        UpdateIr
    } tap_state_e;

    typedef enum logic [IrWidth-1:0] {
        IrIdcode = 5'h01,
        IrDtmcs  = 5'h10,
        IrDmi    = 5'h11,
        IrBypass = 5'h1F
    } ir_e;

    typedef enum logic [1:0] {
        OpNop   = 2'd0,
        OpRead  = 2'd1,
        OpWrite = 2'd2,
        OpBusy  = 2'd3
    } dtm_op_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: state register, next-state logic and state decodes.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic clock,
    input  logic reset_i,
    input  logic trst_i,
    input  logic tck_rise_i,
    input  logic tms_i,
    output logic tlr_o,
    output logic capture_ir_o,
    output logic shift_ir_o,
    output logic update_ir_o,
    output logic capture_dr_o,
    output logic shift_dr_o,
    output logic update_dr_o
);

    tap_state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) state_q <= TestLogicReset;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (trst_i) begin
            state_d = TestLogicReset;
        end else if (tck_rise_i) begin
            unique case (state_q)
                TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
                RunTestIdle:    state_d = tms_i ? SelectDrScan : RunTestIdle;
                SelectDrScan:   state_d = tms_i ? SelectIrScan : CaptureDr;
                CaptureDr:      state_d = tms_i ? Exit1Dr : ShiftDr;
                ShiftDr:        state_d = tms_i ? Exit1Dr : ShiftDr;
                Exit1Dr:        state_d = tms_i ? UpdateDr : PauseDr;
                PauseDr:        state_d = tms_i ? Exit2Dr : PauseDr;
                Exit2Dr:        state_d = tms_i ? UpdateDr : ShiftDr;
                UpdateDr:       state_d = tms_i ? SelectDrScan : RunTestIdle;
                SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
                CaptureIr:      state_d = tms_i ? Exit1Ir : ShiftIr;
                ShiftIr:        state_d = tms_i ? Exit1Ir : ShiftIr;
                Exit1Ir:        state_d = tms_i ? UpdateIr : PauseIr;
                PauseIr:        state_d = tms_i ? Exit2Ir : PauseIr;
                Exit2Ir:        state_d = tms_i ? UpdateIr : ShiftIr;
                UpdateIr:       state_d = tms_i ? SelectDrScan : RunTestIdle;
            endcase
        end
    end

    assign tlr_o        = (state_q == TestLogicReset);
    assign capture_ir_o = (state_q == CaptureIr);
    assign shift_ir_o   = (state_q == ShiftIr);
    assign update_ir_o  = (state_q == UpdateIr);
    assign capture_dr_o = (state_q == CaptureDr);
    assign shift_dr_o   = (state_q == ShiftDr);
    assign update_dr_o  = (state_q == UpdateDr);

endmodule

// File: rtl/jtag_dmi_tap.sv
// Oversampled JTAG TAP + RISC-V DTM bridging DMI scans to a valid/ready DMI port.
// Define JTAG_TAP_TRST_EN to let jtag_trst_ni reset the TAP and IR.
module jtag_dmi_tap
    import jtag_tap_pkg::*;
#(
    parameter logic [31:0] IdcodeValue = 32'h04F5484D,
    parameter int unsigned AbitsW      = 7
) (
    input  logic              clock,
    input  logic              reset_i,
    input  logic              jtag_tck_i,
    input  logic              jtag_tms_i,
    input  logic              jtag_tdi_i,
    input  logic              jtag_trst_ni,
    output logic              jtag_tdo_o,
    output logic              dmi_req_valid_o,
    input  logic              dmi_req_ready_i,
    output logic [AbitsW-1:0] dmi_req_addr_o,
    output logic [1:0]        dmi_req_op_o,
    output logic [31:0]       dmi_req_data_o,
    input  logic              dmi_rsp_valid_i,
    output logic              dmi_rsp_ready_o,
    input  logic [31:0]       dmi_rsp_data_i,
    input  logic [1:0]        dmi_rsp_resp_i,
    output logic              dmi_rst_no
);

    localparam int unsigned DmiW   = AbitsW + 34;
    localparam logic [5:0]  DmiMsb = 6'(DmiW - 1);

    logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
    logic       tck_prev_q;
    logic       tck_rise, tck_fall, tms_s, tdi_s, tap_rst;

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            tck_sync_q <= '0;
            tms_sync_q <= '0;
            tdi_sync_q <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            tck_sync_q <= {tck_sync_q[0], jtag_tck_i};
            tms_sync_q <= {tms_sync_q[0], jtag_tms_i};
            tdi_sync_q <= {tdi_sync_q[0], jtag_tdi_i};
            tck_prev_q <= tck_sync_q[1];
        end
    end

    assign tck_rise = tck_sync_q[1] & ~tck_prev_q;
    assign tck_fall = ~tck_sync_q[1] & tck_prev_q;
    assign tms_s    = tms_sync_q[1];
    assign tdi_s    = tdi_sync_q[1];

`ifdef JTAG_TAP_TRST_EN
    logic [1:0] trst_sync_q;

    always_ff @(posedge clock or posedge reset_i or negedge jtag_trst_ni) begin
        if (reset_i || !jtag_trst_ni) trst_sync_q <= 2'b00;
        else                          trst_sync_q <= {trst_sync_q[0], 1'b1};
    end

    assign tap_rst = ~trst_sync_q[1];
`else
    logic unused_trst;
    assign unused_trst = jtag_trst_ni;
    assign tap_rst     = 1'b0;
`endif

    logic tlr, cap_ir, sh_ir, up_ir, cap_dr, sh_dr, up_dr;

    jtag_tap_fsm u_fsm (
        .clock        (clock),
        .reset_i      (reset_i),
        .trst_i       (tap_rst),
        .tck_rise_i   (tck_rise),
        .tms_i        (tms_s),
        .tlr_o        (tlr),
        .capture_ir_o (cap_ir),
        .shift_ir_o   (sh_ir),
        .update_ir_o  (up_ir),
        .capture_dr_o (cap_dr),
        .shift_dr_o   (sh_dr),
        .update_dr_o  (up_dr)
    );

    logic [IrWidth-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
    logic [DmiW-1:0]    dr_sr_q, dr_sr_d, dr_cap;
    logic [5:0]         dr_msb;
    logic               tdo_q, tdo_d;
    logic [1:0]         dmistat_q, dmistat_d;
    logic               busy_q, busy_d;
    logic               req_valid_q, req_valid_d;
    logic [AbitsW-1:0]  addr_q, addr_d;
    logic [31:0]        data_q, data_d, rsp_data_q, rsp_data_d;
    logic [1:0]         op_q, op_d, cap_op, upd_op;
    logic               rst_n_q, rst_n_d;
    logic               ir_dtmcs, ir_dmi;
    logic [31:0]        dtmcs_cap;

    assign ir_dtmcs  = (ir_q == IrDtmcs);
    assign ir_dmi    = (ir_q == IrDmi);
    assign cap_op    = (dmistat_q != 2'd0) ? dmistat_q : (busy_q ? OpBusy : OpNop);
    assign upd_op    = dr_sr_q[1:0];
    assign dtmcs_cap = {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, dmistat_q, 6'(AbitsW), DtmcsVersion};

    // Unknown IR codes fall through to the 1-bit bypass register.
    always_comb begin
        dr_msb = 6'd0;
        dr_cap = '0;
        unique case (1'b1)
            (ir_q == IrIdcode): begin
                dr_msb = 6'd31;
                dr_cap = {{(DmiW-32){1'b0}}, IdcodeValue};
            end
            ir_dtmcs: begin
                dr_msb = 6'd31;
                dr_cap = {{(DmiW-32){1'b0}}, dtmcs_cap};
            end
            ir_dmi: begin
                dr_msb = DmiMsb;
                dr_cap = {addr_q, rsp_data_q, cap_op};
            end
            default: ;
        endcase
    end

    always_comb begin
        ir_d        = ir_q;
        ir_sr_d     = ir_sr_q;
        dr_sr_d     = dr_sr_q;
        tdo_d       = tdo_q;
        dmistat_d   = dmistat_q;
        busy_d      = busy_q;
        req_valid_d = req_valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        op_d        = op_q;
        rsp_data_d  = rsp_data_q;
        rst_n_d     = 1'b1;

        if (req_valid_q && dmi_req_ready_i) req_valid_d = 1'b0;
        if (busy_q && dmi_rsp_valid_i) begin
            busy_d     = 1'b0;
            rsp_data_d = dmi_rsp_data_i;
            if (dmi_rsp_resp_i != 2'd0 && dmistat_q == 2'd0) dmistat_d = 2'd2;
        end

        if (tck_rise) begin
            if (cap_ir) ir_sr_d = 5'b00001;
            if (sh_ir)  ir_sr_d = {tdi_s, ir_sr_q[IrWidth-1:1]};
            if (cap_dr) begin
                dr_sr_d = dr_cap;
                if (ir_dmi && busy_q && dmistat_q == 2'd0) dmistat_d = OpBusy;
            end
            if (sh_dr) begin
                dr_sr_d         = dr_sr_q >> 1;
                dr_sr_d[dr_msb] = tdi_s;
            end
        end

        if (tck_fall) begin
            tdo_d = sh_ir ? ir_sr_q[0] : (sh_dr ? dr_sr_q[0] : 1'b0);
            if (up_ir) ir_d = ir_sr_q;
            if (up_dr && ir_dtmcs) begin
                if (dr_sr_q[16]) dmistat_d = 2'd0;
                if (dr_sr_q[17]) begin
                    rst_n_d     = 1'b0;
                    req_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            if (up_dr && ir_dmi && (upd_op == OpRead || upd_op == OpWrite)) begin
                if (busy_q) begin
                    dmistat_d = OpBusy;
                end else if (dmistat_q == 2'd0) begin
                    req_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    addr_d      = dr_sr_q[DmiW-1:34];
                    data_d      = dr_sr_q[33:2];
                    op_d        = upd_op;
                end
            end
        end

        if (tlr || tap_rst) ir_d = IrIdcode;
    end

    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            ir_q        <= IrIdcode;
            ir_sr_q     <= '0;
            dr_sr_q     <= '0;
            tdo_q       <= 1'b0;
            dmistat_q   <= 2'd0;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            op_q        <= 2'd0;
            rsp_data_q  <= '0;
            rst_n_q     <= 1'b1;
        end else begin
            ir_q        <= ir_d;
            ir_sr_q     <= ir_sr_d;
            dr_sr_q     <= dr_sr_d;
            tdo_q       <= tdo_d;
            dmistat_q   <= dmistat_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            op_q        <= op_d;
            rsp_data_q  <= rsp_data_d;
            rst_n_q     <= rst_n_d;
        end
    end

    assign jtag_tdo_o      = tdo_q;
    assign dmi_req_valid_o = req_valid_q;
    assign dmi_req_addr_o  = addr_q;
    assign dmi_req_data_o  = data_q;
    assign dmi_req_op_o    = op_q;
    assign dmi_rsp_ready_o = 1'b1;
    assign dmi_rst_no      = rst_n_q;

endmodule

// File: tb/tb_jtag_dmi_tap.sv
// Directed bench for jtag_dmi_tap: JTAG scans driven by tasks, scoreboard queue of expectations.
module tb_jtag_dmi_tap;

    localparam int HALF = 5;

    logic        clock = 1'b0;
    logic        reset_i;
    logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst_n;
    logic        jtag_tdo;
    logic        req_valid, req_ready;
    logic [6:0]  req_addr;
    logic [1:0]  req_op;
    logic [31:0] req_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        dmi_rst_n;

    int checks = 0;
    int errors = 0;
    int rst_low_cnt = 0;

    string       tag_q[$];
    logic [63:0] val_q[$];

    always #5 clock = ~clock;

    always @(posedge clock) if (dmi_rst_n === 1'b0) rst_low_cnt++;

    jtag_dmi_tap dut (
        .clock           (clock),
        .reset_i         (reset_i),
        .jtag_tck_i      (jtag_tck),
        .jtag_tms_i      (jtag_tms),
        .jtag_tdi_i      (jtag_tdi),
        .jtag_trst_ni    (jtag_trst_n),
        .jtag_tdo_o      (jtag_tdo),
        .dmi_req_valid_o (req_valid),
        .dmi_req_ready_i (req_ready),
        .dmi_req_addr_o  (req_addr),
        .dmi_req_op_o    (req_op),
        .dmi_req_data_o  (req_data),
        .dmi_rsp_valid_i (rsp_valid),
        .dmi_rsp_ready_o (rsp_ready),
        .dmi_rsp_data_i  (rsp_data),
        .dmi_rsp_resp_i  (rsp_resp),
        .dmi_rst_no      (dmi_rst_n)
    );

    task automatic push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic pop(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        t = tag_q.pop_front();
        e = val_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e);
        push(tag, e);
        pop(obs);
    endtask

    task automatic clk1();
        @(posedge clock);
        #1;
    endtask

    // One TCK period: falling half, sample TDO, rising half.
    task automatic tick(input logic tms, input logic tdi, output logic tdo);
        jtag_tms = tms;
        jtag_tdi = tdi;
        jtag_tck = 1'b0;
        repeat (HALF) @(posedge clock);
        #1;
        tdo = jtag_tdo;
        jtag_tck = 1'b1;
        repeat (HALF) @(posedge clock);
        #1;
    endtask

    // From Run-Test/Idle through a full IR or DR scan back to Run-Test/Idle.
    task automatic scan(input bit ir, input int len, input logic [63:0] din,
                        output logic [63:0] dout);
        logic t;
        dout = '0;
        tick(1'b1, 1'b0, t);
        if (ir) tick(1'b1, 1'b0, t);
        tick(1'b0, 1'b0, t);
        tick(1'b0, 1'b0, t);
        for (int i = 0; i < len; i++) begin
            tick(i == len - 1, din[i], t);
            dout[i] = t;
        end
        tick(1'b1, 1'b0, t);
        tick(1'b0, 1'b0, t);
    endtask

    initial begin
        logic [63:0] d;
        logic        t;

        reset_i     = 1'b1;
        jtag_tck    = 1'b1;
        jtag_tms    = 1'b1;
        jtag_tdi    = 1'b0;
        jtag_trst_n = 1'b1;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_data    = '0;
        rsp_resp    = '0;
        repeat (3) clk1();
        reset_i = 1'b0;
        clk1();

        chk("rst_tdo", jtag_tdo, 0);
        chk("rst_valid", req_valid, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_op", req_op, 0);
        chk("rst_data", req_data, 0);
        chk("rst_dmi_rst_n", dmi_rst_n, 1);
        chk("rsp_ready", rsp_ready, 1);

        // IDCODE
        repeat (5) tick(1'b1, 1'b0, t);
        tick(1'b0, 1'b0, t);
        push("idcode", 64'h04F5484D);
        scan(0, 32, 0, d);
        pop(d);

        // DTMCS and bypass
        push("ir_capture", 64'h01);
        scan(1, 5, 64'h10, d);
        pop(d);
        push("dtmcs_rst", 64'h1071);
        scan(0, 32, 0, d);
        pop(d);
        scan(1, 5, 64'h1F, d);
        push("bypass_echo", 64'h6C);
        scan(0, 8, 64'hB6, d);
        pop(d);
        scan(1, 5, 64'h07, d);
        push("bypass_unknown_ir", 64'h6C);
        scan(0, 8, 64'hB6, d);
        pop(d);

        // DMI write with back-pressure
        scan(1, 5, 64'h11, d);
        push("dmi_cap_idle", 64'h0);
        scan(0, 41, {7'h10, 32'h1, 2'd2}, d);
        pop(d);
        repeat (3) begin
            clk1();
            chk("wr_valid_held", req_valid, 1);
        end
        chk("wr_addr", req_addr, 64'h10);
        chk("wr_data", req_data, 64'h1);
        chk("wr_op", req_op, 64'h2);
        req_ready = 1'b1;
        clk1();
        req_ready = 1'b0;
        chk("wr_valid_drop", req_valid, 0);
        rsp_valid = 1'b1;
        clk1();
        rsp_valid = 1'b0;

        // DMI read left outstanding, busy reporting and dmireset
        push("dmi_cap_after_wr", {23'd0, 7'h10, 32'h0, 2'd0});
        scan(0, 41, {7'h11, 32'h0, 2'd1}, d);
        pop(d);
        chk("rd_op", req_op, 64'h1);
        req_ready = 1'b1;
        clk1();
        req_ready = 1'b0;
        push("dmi_busy", {23'd0, 7'h11, 32'h0, 2'd3});
        scan(0, 41, 0, d);
        pop(d);
        scan(1, 5, 64'h10, d);
        push("dtmcs_busy", 64'h1C71);
        scan(0, 32, 64'h10000, d);
        pop(d);
        push("dtmcs_cleared", 64'h1071);
        scan(0, 32, 0, d);
        pop(d);
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEADBEEF;
        clk1();
        rsp_valid = 1'b0;
        scan(1, 5, 64'h11, d);
        push("dmi_rd_data", {23'd0, 7'h11, 32'hDEADBEEF, 2'd0});
        scan(0, 41, {7'h05, 32'h0, 2'd1}, d);
        pop(d);

        // Failed read accepted and answered in the same clock
        req_ready = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = 32'h12345678;
        rsp_resp  = 2'd2;
        clk1();
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_resp  = 2'd0;
        chk("same_clk_valid_drop", req_valid, 0);
        push("dmi_failed", {23'd0, 7'h05, 32'h12345678, 2'd2});
        scan(0, 41, 0, d);
        pop(d);
        scan(1, 5, 64'h10, d);
        push("dtmcs_failed", 64'h1871);
        scan(0, 32, 64'h10000, d);
        pop(d);

        // dmihardreset drops a pending request
        scan(1, 5, 64'h11, d);
        push("dmi_cap_clear", {23'd0, 7'h05, 32'h12345678, 2'd0});
        scan(0, 41, {7'h22, 32'hA5, 2'd2}, d);
        pop(d);
        chk("hr_valid_before", req_valid, 1);
        scan(1, 5, 64'h10, d);
        rst_low_cnt = 0;
        push("dtmcs_pre_hr", 64'h1071);
        scan(0, 32, 64'h20000, d);
        pop(d);
        chk("hr_pulse_len", rst_low_cnt, 1);
        chk("hr_valid_after", req_valid, 0);
        scan(1, 5, 64'h11, d);
        push("dmi_after_hr", {23'd0, 7'h22, 32'h12345678, 2'd0});
        scan(0, 41, {7'h33, 32'h77, 2'd2}, d);
        pop(d);

        // reset_i in the middle of a DR shift with a request pending
        chk("mid_valid", req_valid, 1);
        tick(1'b1, 1'b0, t);
        tick(1'b0, 1'b0, t);
        tick(1'b0, 1'b0, t);
        tick(1'b0, 1'b1, t);
        chk("mid_tdo", t, 1);
        jtag_tms = 1'b1;
        reset_i  = 1'b1;
        #1;
        chk("mr_valid", req_valid, 0);
        chk("mr_tdo", jtag_tdo, 0);
        chk("mr_addr", req_addr, 0);
        clk1();
        reset_i = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0BAD0BAD;
        clk1();
        rsp_valid = 1'b0;
        tick(1'b0, 1'b0, t);
        push("mr_idcode", 64'h04F5484D);
        scan(0, 32, 0, d);
        pop(d);
        scan(1, 5, 64'h11, d);
        push("mr_rsp_discarded", 64'h0);
        scan(0, 41, 0, d);
        pop(d);

`ifdef JTAG_TAP_TRST_EN
        scan(1, 5, 64'h10, d);
        jtag_trst_n = 1'b0;
        repeat (4) clk1();
        jtag_trst_n = 1'b1;
        repeat (4) clk1();
        tick(1'b0, 1'b0, t);
        push("trst_idcode", 64'h04F5484D);
        scan(0, 32, 0, d);
        pop(d);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
